// File: rtl/vga_text_renderer_if.sv
// Bundle of the pixel-timing, text-write, cursor and font-ROM signals
// exchanged between the text renderer and its surroundings.
interface vga_text_renderer_if;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        video_on;
  logic        hsync_i;
  logic        vsync_i;
  logic        wr_en;
  logic [6:0]  wr_col;
  logic [4:0]  wr_row;
  logic [6:0]  wr_char;
  logic        clear_req;
  logic        cursor_en;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] rgb;
  logic        hsync_o;
  logic        vsync_o;
  logic        video_on_o;
  logic        busy;

  modport slave (
    input  px_x, px_y, video_on, hsync_i, vsync_i,
    input  wr_en, wr_col, wr_row, wr_char, clear_req,
    input  cursor_en, cursor_col, cursor_row, font_data,
    output font_addr, rgb, hsync_o, vsync_o, video_on_o, busy
  );

  modport master (
    output px_x, px_y, video_on, hsync_i, vsync_i,
    output wr_en, wr_col, wr_row, wr_char, clear_req,
    output cursor_en, cursor_col, cursor_row, font_data,
    input  font_addr, rgb, hsync_o, vsync_o, video_on_o, busy
  );
endinterface

// File: rtl/vga_text_renderer.sv
// Character-cell text stage: text buffer, font ROM addressing, glyph
// serialisation to RGB444, sync alignment, blinking cursor and clear engine.
module vga_text_renderer #(
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic        SYNC_IDLE    = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  vga_text_renderer_if.slave bus
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]  COLS_L = 7'(COLS);
  localparam logic [4:0]  ROWS_L = 5'(ROWS);
  localparam logic [6:0]  BLANK  = 7'h20;

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic            busy_q, busy_d;

  logic [6:0]      rd_col;
  logic [4:0]      rd_row;
  logic            rd_in_range;
  logic [AW-1:0]   rd_addr;
  logic            cursor_hit;

  logic            wr_ok;
  logic [AW-1:0]   wr_addr;
  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [6:0]      mem_wd;

  // Cells are stored XOR 0x20 so a zero-initialised array reads back as spaces.
  logic [6:0]      mem [DEPTH];
  logic [6:0]      mem_q;

  logic [2:0]      x_d1, x_d2;
  logic [3:0]      y_d1;
  logic            video_d1, video_d2;
  logic            hs_d1, hs_d2, vs_d1, vs_d2;
  logic            cur_d1, cur_d2;
  logic            blank_d1;
  logic [6:0]      char_q;

  logic [11:0]     rgb_q;
  logic            hs_q, vs_q, video_q;
  logic            glyph_bit;

  logic            vs_prev;
  logic            frame_tick;
  logic [FW-1:0]   frame_cnt;
  logic            blink_q;

  assign rd_col      = bus.px_x[9:3];
  assign rd_row      = bus.px_y[8:4];
  assign rd_in_range = !bus.px_y[9] && (rd_col < COLS_L) && (rd_row < ROWS_L);
  assign rd_addr     = AW'(rd_row) * AW'(COLS) + AW'(rd_col);
  assign cursor_hit  = (rd_col == bus.cursor_col) && (rd_row == bus.cursor_row);

  assign wr_ok   = bus.wr_en && !busy_q && (bus.wr_col < COLS_L) && (bus.wr_row < ROWS_L);
  assign wr_addr = AW'(bus.wr_row) * AW'(COLS) + AW'(bus.wr_col);

  // The clear engine owns the single write port while busy.
  assign mem_we = rst_n && (busy_q || wr_ok);
  assign mem_wa = busy_q ? clr_addr_q : wr_addr;
  assign mem_wd = busy_q ? 7'h00 : (bus.wr_char ^ BLANK);

  // Old data on read-during-write falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
    if (rd_in_range) begin
      mem_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    busy_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (clr_addr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  // S1: RAM read issued above, side-band captured here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_d1     <= '0;
      y_d1     <= '0;
      video_d1 <= 1'b0;
      hs_d1    <= SYNC_IDLE;
      vs_d1    <= SYNC_IDLE;
      cur_d1   <= 1'b0;
      blank_d1 <= 1'b1;
    end else begin
      x_d1     <= bus.px_x[2:0];
      y_d1     <= bus.px_y[3:0];
      video_d1 <= bus.video_on;
      hs_d1    <= bus.hsync_i;
      vs_d1    <= bus.vsync_i;
      cur_d1   <= cursor_hit;
      blank_d1 <= !rd_in_range;
    end
  end

  assign char_q        = blank_d1 ? BLANK : (mem_q ^ BLANK);
  assign bus.font_addr = {char_q, y_d1};

  // S2: side-band waits while the font ROM registers its row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_d2     <= '0;
      video_d2 <= 1'b0;
      hs_d2    <= SYNC_IDLE;
      vs_d2    <= SYNC_IDLE;
      cur_d2   <= 1'b0;
    end else begin
      x_d2     <= x_d1;
      video_d2 <= video_d1;
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
      cur_d2   <= cur_d1;
    end
  end

  // S3: pick the glyph bit (bit 7 leftmost), apply cursor inversion, colour it.
  assign glyph_bit = bus.font_data[3'd7 - x_d2] ^ (cur_d2 && bus.cursor_en && blink_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hs_q    <= SYNC_IDLE;
      vs_q    <= SYNC_IDLE;
      video_q <= 1'b0;
    end else begin
      rgb_q   <= video_d2 ? (glyph_bit ? FG_COLOR : BG_COLOR) : 12'h000;
      hs_q    <= hs_d2;
      vs_q    <= vs_d2;
      video_q <= video_d2;
    end
  end

  assign frame_tick = (vs_prev == SYNC_IDLE) && (bus.vsync_i != SYNC_IDLE);

  // One frame per vsync assertion; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev   <= SYNC_IDLE;
      frame_cnt <= '0;
      blink_q   <= 1'b0;
    end else begin
      vs_prev <= bus.vsync_i;
      if (frame_tick) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_q   <= !blink_q;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.hsync_o    = hs_q;
  assign bus.vsync_o    = vs_q;
  assign bus.video_on_o = video_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Directed bench for vga_text_renderer with a small synchronous font ROM model.
module tb_vga_text_renderer;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vga_text_renderer_if bus();

  vga_text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Blank is empty, 'A' row 3 is 00011000, other glyphs are {code[3:0], row}.
  function automatic logic [7:0] font(input logic [10:0] a);
    logic [6:0] c;
    logic [3:0] r;
    c = a[10:4];
    r = a[3:0];
    if (c == 7'h20) return 8'h00;
    if (c == 7'd65) return (r == 4'd3) ? 8'h18 : 8'h66;
    return {c[3:0], r};
  endfunction

  always @(posedge clk) bus.font_data <= font(bus.font_addr);

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.px_x = '0; bus.px_y = '0; bus.video_on = 1'b0;
    bus.hsync_i = 1'b1; bus.vsync_i = 1'b1;
    bus.wr_en = 1'b0; bus.wr_col = '0; bus.wr_row = '0; bus.wr_char = '0;
    bus.clear_req = 1'b0; bus.cursor_en = 1'b0; bus.cursor_col = '0; bus.cursor_row = '0;
  endtask

  task automatic do_write(input int col, input int row, input logic [6:0] ch);
    bus.wr_en = 1'b1; bus.wr_col = 7'(col); bus.wr_row = 5'(row); bus.wr_char = ch;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic read_char(input int col, input int row, output logic [6:0] ch);
    bus.px_x = 10'(col * 8);
    bus.px_y = 10'(row * 16);
    step();
    ch = bus.font_addr[10:4];
  endtask

  // Scans 8 pixels from (x0,y) and collects the aligned outputs 3 edges later.
  task automatic scan8(input int x0, input int y, input logic [7:0] hs, input logic [7:0] vs,
                       output logic [95:0] pix, output logic [7:0] hso, output logic [7:0] vso,
                       output logic [10:0] fa0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        bus.px_x = 10'(x0 + i); bus.px_y = 10'(y); bus.video_on = 1'b1;
        bus.hsync_i = hs[7 - i]; bus.vsync_i = vs[7 - i];
      end else begin
        bus.video_on = 1'b0; bus.hsync_i = 1'b1; bus.vsync_i = 1'b1;
      end
      step();
      if (i == 0) fa0 = bus.font_addr;
      if (i >= 2) begin
        pix[(i - 2) * 12 +: 12] = bus.rgb;
        hso[9 - i] = bus.hsync_o;
        vso[9 - i] = bus.vsync_o;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.hsync_i = 1'b0; bus.vsync_i = 1'b0; bus.video_on = 1'b1;
    rst_n = 1'b0;
    step(); step();
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h exp 000", bus.rgb); end
    checks++; if (bus.hsync_o !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b exp 1", bus.hsync_o); end
    checks++; if (bus.vsync_o !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b exp 1", bus.vsync_o); end
    checks++; if (bus.video_on_o !== 1'b0) begin errors++; $display("FAIL reset_video_on: got %b exp 0", bus.video_on_o); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.font_addr !== 11'd512) begin errors++; $display("FAIL reset_font_addr: got %0d exp 512", bus.font_addr); end
    idle_inputs();
    rst_n = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_latency();
    logic [95:0] pix; logic [7:0] hso, vso; logic [10:0] fa0;
    logic [11:0] exp_px;
    logic [7:0]  pat;
    pat = 8'h18;
    do_write(0, 0, 7'd65);
    scan8(0, 3, 8'b1011_0010, 8'b1100_1111, pix, hso, vso, fa0);
    checks++; if (fa0 !== 11'd1043) begin errors++; $display("FAIL latency_font_addr: got %0d exp 1043", fa0); end
    for (int i = 0; i < 8; i++) begin
      exp_px = pat[7 - i] ? FG : BG;
      checks++;
      if (pix[i * 12 +: 12] !== exp_px) begin
        errors++; $display("FAIL latency_px%0d: got %h exp %h", i, pix[i * 12 +: 12], exp_px);
      end
    end
    checks++; if (hso !== 8'b1011_0010) begin errors++; $display("FAIL latency_hsync: got %b exp 10110010", hso); end
    checks++; if (vso !== 8'b1100_1111) begin errors++; $display("FAIL latency_vsync: got %b exp 11001111", vso); end
    idle_inputs();
  endtask

  task automatic test_bounds();
    logic [95:0] pix; logic [7:0] hso, vso; logic [10:0] fa0;
    logic [6:0]  ch;
    do_write(0, 2, 7'd66);
    do_write(80, 0, 7'd67);
    do_write(0, 30, 7'd67);
    do_write(127, 31, 7'd67);
    read_char(0, 1, ch);
    checks++; if (ch !== 7'h20) begin errors++; $display("FAIL bounds_col80_alias: got %h exp 20", ch); end
    read_char(0, 2, ch);
    checks++; if (ch !== 7'd66) begin errors++; $display("FAIL bounds_valid_write: got %h exp 42", ch); end
    read_char(0, 30, ch);
    checks++; if (ch !== 7'h20) begin errors++; $display("FAIL bounds_row30_read: got %h exp 20", ch); end
    scan8(640, 19, 8'hFF, 8'hFF, pix, hso, vso, fa0);
    checks++; if (fa0 !== 11'd515) begin errors++; $display("FAIL bounds_x640_font_addr: got %0d exp 515", fa0); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pix[i * 12 +: 12] !== BG) begin
        errors++; $display("FAIL bounds_x640_px%0d: got %h exp %h", i, pix[i * 12 +: 12], BG);
      end
    end
    idle_inputs();
  endtask

  task automatic test_read_during_write();
    do_write(10, 4, 7'd67);
    bus.px_x = 10'd80; bus.px_y = 10'd69;
    bus.wr_en = 1'b1; bus.wr_col = 7'd10; bus.wr_row = 5'd4; bus.wr_char = 7'd68;
    step();
    bus.wr_en = 1'b0;
    checks++; if (bus.font_addr !== 11'd1077) begin errors++; $display("FAIL rdw_old_data: got %0d exp 1077", bus.font_addr); end
    step();
    checks++; if (bus.font_addr !== 11'd1093) begin errors++; $display("FAIL rdw_new_data: got %0d exp 1093", bus.font_addr); end
    idle_inputs();
  endtask

  task automatic test_cursor();
    logic [95:0] pix; logic [7:0] hso, vso; logic [10:0] fa0;
    logic [7:0]  pat;
    logic [11:0] exp_px;
    idle_inputs();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    do_write(5, 2, 7'd65);
    bus.cursor_en = 1'b1; bus.cursor_col = 7'd5; bus.cursor_row = 5'd2;
    for (int f = 0; f < 6; f++) begin
      if (f > 0) begin
        bus.vsync_i = 1'b0; step();
        bus.vsync_i = 1'b1; step();
      end
      pat = (f == 2 || f == 3) ? 8'hE7 : 8'h18;
      scan8(40, 35, 8'hFF, 8'hFF, pix, hso, vso, fa0);
      for (int i = 0; i < 8; i++) begin
        exp_px = pat[7 - i] ? FG : BG;
        checks++;
        if (pix[i * 12 +: 12] !== exp_px) begin
          errors++; $display("FAIL cursor_f%0d_px%0d: got %h exp %h", f, i, pix[i * 12 +: 12], exp_px);
        end
      end
      if (f == 2) begin
        scan8(48, 35, 8'hFF, 8'hFF, pix, hso, vso, fa0);
        checks++;
        if (pix !== {8{BG}}) begin errors++; $display("FAIL cursor_neighbour: got %h exp all %h", pix, BG); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    int n;
    int bad;
    logic [6:0] ch;
    do_write(0, 0, 7'd69);
    do_write(79, 29, 7'd69);
    bus.clear_req = 1'b1; step(); bus.clear_req = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start: got %b exp 1", bus.busy); end
    n = 0;
    while (bus.busy === 1'b1 && n < 5000) begin
      n++;
      bus.clear_req = (n == 100);
      bus.wr_en = (n == 100); bus.wr_col = 7'd5; bus.wr_row = 5'd0; bus.wr_char = 7'h5A;
      step();
    end
    bus.clear_req = 1'b0; bus.wr_en = 1'b0;
    checks++; if (n !== 2400) begin errors++; $display("FAIL clear_busy_cycles: got %0d exp 2400", n); end
    bad = 0;
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 80; c++) begin
        read_char(c, r, ch);
        if (ch !== 7'h20) bad++;
      end
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_cells_blank: got %0d non-blank cells exp 0", bad); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_clear();
    logic [6:0] ch;
    do_write(20, 6, 7'd81);
    do_write(60, 18, 7'd81);
    bus.video_on = 1'b1; bus.hsync_i = 1'b0; bus.vsync_i = 1'b0;
    bus.clear_req = 1'b1; step(); bus.clear_req = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midclear_busy_before: got %b exp 1", bus.busy); end
    rst_n = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclear_busy: got %b exp 0", bus.busy); end
    checks++; if (bus.rgb !== 12'h000) begin errors++; $display("FAIL midclear_rgb: got %h exp 000", bus.rgb); end
    checks++; if (bus.hsync_o !== 1'b1) begin errors++; $display("FAIL midclear_hsync: got %b exp 1", bus.hsync_o); end
    checks++; if (bus.vsync_o !== 1'b1) begin errors++; $display("FAIL midclear_vsync: got %b exp 1", bus.vsync_o); end
    checks++; if (bus.video_on_o !== 1'b0) begin errors++; $display("FAIL midclear_video_on: got %b exp 0", bus.video_on_o); end
    idle_inputs();
    rst_n = 1'b1;
    step();
    read_char(20, 6, ch);
    checks++; if (ch !== 7'h20) begin errors++; $display("FAIL midclear_cell500: got %h exp 20", ch); end
    read_char(60, 18, ch);
    checks++; if (ch !== 7'd81) begin errors++; $display("FAIL midclear_cell1500: got %h exp 51", ch); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midclear_no_restart: got %b exp 0", bus.busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    test_reset();
    test_latency();
    test_bounds();
    test_read_during_write();
    test_cursor();
    test_clear();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
